// File: rtl/psum_accum_pkg.sv
// Shared types and constants for the partial-sum accumulator.
// Q24.8 word width, saturation bounds and the group FSM state encoding.
// Imported by the accumulator top and its saturating adder.
package psum_accum_pkg;

   // Default Q24.8 word width used across the accumulator datapath.
   localparam int DW = 24 + 8;

   // 1.0 in Q24.8.
   localparam logic [DW-1:0] Q_ONE = 32'h0000_0100;

   // Clamp bounds for a signed DW-bit lane.
   localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
   localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

   // Group FSM: IDLE waits for the first beat of a group, ACCUM sums the rest.
   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

endpackage : psum_accum_pkg

// File: rtl/psum_accum_sat_add.sv
// Signed saturating adder: W + W -> W, clamped to the signed W-bit range.
// Latency: combinational.
// Backpressure: none, pure datapath.
module psum_accum_sat_add
   import psum_accum_pkg::*;
#(
   parameter int W = DW
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic [W-1:0] o_sum
);

   localparam logic [W-1:0] L_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] L_MIN = {1'b1, {(W-1){1'b0}}};

   logic [W:0] w_wide;

   // One guard bit is enough: two W-bit signed values never overflow W+1 bits.
   assign w_wide = {i_a[W-1], i_a} + {i_b[W-1], i_b};

   // Guard bit disagreeing with the sign bit means the W-bit result wrapped;
   // the guard bit carries the true sign, so it picks which rail to clamp to.
   always_comb begin
      o_sum = w_wide[W-1:0];
      if (w_wide[W] != w_wide[W-1]) begin
         o_sum = w_wide[W] ? L_MIN : L_MAX;
      end
   end

endmodule : psum_accum_sat_add

// File: rtl/psum_accum.sv
// Accumulates per-cycle Q24.8 partial sums over a group of beats and emits one
// saturated (optionally ReLU'd) LANES-wide result beat.
// Latency: result valid 1 cycle after the last beat of a group is accepted.
// Backpressure: only a group-completing beat is stalled, and only while a
// previous result is pending and not being taken; other beats always accepted.
module psum_accum
   import psum_accum_pkg::*;
#(
   parameter int LANES = 9,
   parameter int IW    = 24,
   parameter int FW    = 8,
   parameter int LEN_W = 10
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [LEN_W-1:0]          acc_len_i,
   input  logic                      relu_en_i,
   input  logic [LANES*(IW+FW)-1:0]  psum_i,
   input  logic                      psum_valid_i,
   output logic                      psum_ready_o,
   output logic [LANES*(IW+FW)-1:0]  res_o,
   output logic                      res_valid_o,
   input  logic                      res_ready_i,
   output logic                      busy_o
);

   localparam int W = IW + FW;

   state_t               r_state;
   state_t               w_state_nxt;

   // Group context latched from the first beat of each group.
   logic [LEN_W-1:0]     r_len;
   logic                 r_relu;
   logic [LEN_W-1:0]     r_cnt;

   // Accumulator bank and the output (second) buffer.
   logic [LANES*W-1:0]   r_acc;
   logic [LANES*W-1:0]   r_res;
   logic                 r_res_vld;

   logic [LEN_W-1:0]     w_len_in;
   logic                 w_final;
   logic                 w_relu;
   logic                 w_take;
   logic                 w_accept;
   logic                 w_emit;
   logic [LANES*W-1:0]   w_sum;
   logic [LANES*W-1:0]   w_res_nxt;

   // A zero length would never terminate a group, so it is treated as 1.
   assign w_len_in = (acc_len_i == '0) ? LEN_W'(1) : acc_len_i;

   // Decide whether the beat on the input would close the group, and which
   // ReLU setting applies to it (live input in IDLE, latched copy in ACCUM).
   always_comb begin
      w_final = 1'b0;
      w_relu  = r_relu;
      if (r_state == IDLE) begin
         w_final = (w_len_in == LEN_W'(1));
         w_relu  = relu_en_i;
      end else begin
         w_final = (r_cnt == (r_len - LEN_W'(1)));
      end
   end

   assign w_take       = r_res_vld && res_ready_i;
   // The output buffer frees up in the same cycle it is taken, so a final beat
   // only has to wait when the pending result is not leaving this cycle.
   assign psum_ready_o = !(w_final && r_res_vld && !res_ready_i);
   assign w_accept     = psum_valid_i && psum_ready_o;
   assign w_emit       = w_accept && w_final;

   // The accumulator is held at zero outside a group, so the first beat goes
   // through the same adder path as every later beat.
   genvar k;
   generate
      for (k = 0; k < LANES; k++) begin : g_lane
         psum_accum_sat_add #(
            .W (W)
         ) u_sat_add (
            .i_a   (r_acc[k*W +: W]),
            .i_b   (psum_i[k*W +: W]),
            .o_sum (w_sum[k*W +: W])
         );

         assign w_res_nxt[k*W +: W] = (w_relu && w_sum[k*W + W - 1]) ? '0 : w_sum[k*W +: W];
      end
   endgenerate

   // Next-state: leave IDLE only for multi-beat groups, return when one closes.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept && !w_final) begin
               w_state_nxt = ACCUM;
            end
         end
         ACCUM: begin
            if (w_emit) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Capture group length and ReLU mode on the first beat; later changes are ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_len  <= LEN_W'(1);
         r_relu <= 1'b0;
      end else if (w_accept && (r_state == IDLE)) begin
         r_len  <= w_len_in;
         r_relu <= relu_en_i;
      end
   end

   // Accumulate each accepted beat; clear bank and count when the group closes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (w_accept) begin
         if (w_final) begin
            r_acc <= '0;
            r_cnt <= '0;
         end else begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + LEN_W'(1);
         end
      end
   end

   // Output buffer: load on group close (even while the old result is being
   // taken, so there is no bubble), drop valid when taken with nothing new.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_res     <= '0;
         r_res_vld <= 1'b0;
      end else if (w_emit) begin
         r_res     <= w_res_nxt;
         r_res_vld <= 1'b1;
      end else if (w_take) begin
         r_res_vld <= 1'b0;
      end
   end

   assign res_o       = r_res;
   assign res_valid_o = r_res_vld;
   assign busy_o      = (r_state == ACCUM) || r_res_vld;

endmodule : psum_accum

// File: tb/tb_psum_accum.sv
// Self-checking bench for psum_accum: drives groups of partial-sum beats,
// predicts each result with an independent wide-integer model, and checks
// results, hold stability, backpressure and reset behaviour.
module tb_psum_accum;
   import psum_accum_pkg::*;

   localparam int LANES = 9;
   localparam int LEN_W = 10;
   localparam int VW    = LANES * 32;

   typedef logic [VW-1:0] vec_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [LEN_W-1:0] acc_len_i;
   logic             relu_en_i;
   vec_t             psum_i;
   logic             psum_valid_i;
   logic             psum_ready_o;
   vec_t             res_o;
   logic             res_valid_o;
   logic             res_ready_i;
   logic             busy_o;

   int   n_checks = 0;
   int   n_fail   = 0;
   vec_t sb[$];
   vec_t beats[0:7];
   vec_t mon_exp;

   psum_accum #(
      .LANES (LANES),
      .IW    (24),
      .FW    (8),
      .LEN_W (LEN_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .acc_len_i    (acc_len_i),
      .relu_en_i    (relu_en_i),
      .psum_i       (psum_i),
      .psum_valid_i (psum_valid_i),
      .psum_ready_o (psum_ready_o),
      .res_o        (res_o),
      .res_valid_o  (res_valid_o),
      .res_ready_i  (res_ready_i),
      .busy_o       (busy_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input vec_t got, input vec_t exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] msat(input longint s);
      if (s > 64'sd2147483647)       return SAT_MAX;
      else if (s < -64'sd2147483648) return SAT_MIN;
      else                           return s[31:0];
   endfunction

   function automatic vec_t all_lanes(input logic [31:0] v);
      vec_t r;
      for (int k = 0; k < LANES; k++) r[k*32 +: 32] = v;
      return r;
   endfunction

   // Present one beat and wait (bounded) until it is accepted.
   task automatic send(input vec_t d, input logic [LEN_W-1:0] len, input logic relu);
      int g;
      g = 0;
      @(negedge clk);
      psum_i       = d;
      acc_len_i    = len;
      relu_en_i    = relu;
      psum_valid_i = 1'b1;
      #1;
      while (!psum_ready_o && g < 200) begin
         @(negedge clk);
         #1;
         g++;
      end
      chk("accept_wait", vec_t'(psum_ready_o), vec_t'(1));
      @(posedge clk);
      #1;
      psum_valid_i = 1'b0;
      psum_i       = {9{$urandom()}};
      acc_len_i    = LEN_W'($urandom_range(0, 7));
   endtask

   // Model the group from beats[0..nb-1], queue the expected result, then drive it.
   task automatic run_group(input int nb, input logic [LEN_W-1:0] len_first,
                            input logic [LEN_W-1:0] len_rest, input logic relu);
      vec_t        e;
      logic [31:0] a;
      for (int k = 0; k < LANES; k++) begin
         a = '0;
         for (int b = 0; b < nb; b++) begin
            a = msat(longint'($signed(a)) + longint'($signed(beats[b][k*32 +: 32])));
         end
         if (relu && a[31]) a = '0;
         e[k*32 +: 32] = a;
      end
      sb.push_back(e);
      for (int b = 0; b < nb; b++) begin
         send(beats[b], (b == 0) ? len_first : len_rest, relu);
      end
   endtask

   task automatic set_res_ready(input logic v);
      @(posedge clk);
      #2;
      res_ready_i = v;
   endtask

   // Scoreboard: pop on every take, and check held data against the head otherwise.
   always @(negedge clk) begin
      if (!rst && res_valid_o) begin
         if (sb.size() == 0) begin
            chk("unexpected_res", vec_t'(res_valid_o), vec_t'(0));
         end else if (res_ready_i) begin
            mon_exp = sb.pop_front();
            chk("res", res_o, mon_exp);
         end else begin
            chk("hold", res_o, sb[0]);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b1;
      acc_len_i    = '0;
      relu_en_i    = 1'b0;
      psum_i       = '0;
      psum_valid_i = 1'b0;
      res_ready_i  = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", vec_t'(res_valid_o), vec_t'(0));
      chk("rst_busy", vec_t'(busy_o), vec_t'(0));
      chk("rst_res", res_o, vec_t'(0));
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_ready", vec_t'(psum_ready_o), vec_t'(1));

      // 1: len=3, all lanes 1.0 x3 -> 3.0, valid one cycle after last beat
      for (int b = 0; b < 3; b++) beats[b] = all_lanes(Q_ONE);
      sb.push_back(all_lanes(32'h0000_0300));
      send(beats[0], 10'd3, 1'b0);
      chk("busy_in_group", vec_t'(busy_o), vec_t'(1));
      send(beats[1], 10'd3, 1'b0);
      chk("no_early_valid", vec_t'(res_valid_o), vec_t'(0));
      send(beats[2], 10'd3, 1'b0);
      chk("latency1", vec_t'(res_valid_o), vec_t'(1));
      repeat (2) @(posedge clk);

      // 2: ReLU clamps a negative lane, positive lane passes
      beats[0] = '0;
      beats[1] = '0;
      beats[0][31:0]  = 32'hFFFF_FE00;
      beats[1][31:0]  = 32'h0000_0100;
      beats[0][63:32] = 32'h0000_0080;
      beats[1][63:32] = 32'h0000_0080;
      run_group(2, 10'd2, 10'd2, 1'b1);
      repeat (2) @(posedge clk);

      // 3: positive and negative saturation
      beats[0] = all_lanes(32'h7FFF_FF00);
      beats[1] = all_lanes(32'h7FFF_FF00);
      run_group(2, 10'd2, 10'd2, 1'b0);
      beats[0] = all_lanes(32'h8000_0100);
      beats[1] = all_lanes(32'h8000_0100);
      run_group(2, 10'd2, 10'd2, 1'b0);
      repeat (2) @(posedge clk);

      // 4: len=1 back-to-back with consumer stalled for 5 cycles
      set_res_ready(1'b0);
      beats[0] = all_lanes(32'h0000_0A00);
      run_group(1, 10'd1, 10'd1, 1'b0);
      beats[0] = all_lanes(32'hFFFF_F000);
      fork
         run_group(1, 10'd1, 10'd1, 1'b0);
         begin
            @(negedge clk);
            #2;
            chk("bp_ready_low", vec_t'(psum_ready_o), vec_t'(0));
         end
         begin
            repeat (5) @(posedge clk);
            #2;
            res_ready_i = 1'b1;
         end
      join
      chk("no_bubble", vec_t'(res_valid_o), vec_t'(1));
      repeat (3) @(posedge clk);

      // 5: length 0 acts as 1; mid-group length change ignored
      beats[0] = all_lanes(32'h0000_0123);
      run_group(1, 10'd0, 10'd0, 1'b0);
      for (int b = 0; b < 4; b++) beats[b] = all_lanes(32'h0000_0100 * (b + 1));
      run_group(4, 10'd4, 10'd2, 1'b0);
      repeat (3) @(posedge clk);

      // Random groups with values large enough to exercise saturation
      for (int g = 0; g < 4; g++) begin
         for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < LANES; k++) beats[b][k*32 +: 32] = $urandom();
         end
         run_group(3, 10'd3, LEN_W'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end
      repeat (3) @(posedge clk);

      // 6: reset mid-group with a result pending discards both
      set_res_ready(1'b0);
      beats[0] = all_lanes(32'h0000_0500);
      run_group(1, 10'd1, 10'd1, 1'b0);
      send(all_lanes(32'h0000_7700), 10'd4, 1'b0);
      send(all_lanes(32'h0000_7700), 10'd4, 1'b0);
      @(negedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("midrst_valid", vec_t'(res_valid_o), vec_t'(0));
      chk("midrst_busy", vec_t'(busy_o), vec_t'(0));
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      res_ready_i = 1'b1;
      #1;
      chk("midrst_ready", vec_t'(psum_ready_o), vec_t'(1));
      for (int b = 0; b < 4; b++) beats[b] = all_lanes(32'h0000_0010 << b);
      run_group(4, 10'd4, 10'd4, 1'b0);

      // Drain scoreboard
      for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
      chk("drain", vec_t'(sb.size()), vec_t'(0));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_psum_accum
